// File: rtl/timer_ctrl.sv
// MM:SS countdown timer controller: set digits with buttons, count down on a
// one-second timebase, then hold an alarm for ALARM_TICKS seconds.
module timer_ctrl #(
    parameter int ALARM_TICKS   = 10,
    parameter bit TICK_IS_LEVEL = 1'b0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        tick_1hz,
    input  logic        btn_start,
    input  logic        btn_inc,
    input  logic        btn_mode,
    output logic [15:0] digits,
    output logic [2:0]  state,
    output logic        running,
    output logic        alarm
);

    localparam int CNT_W = $clog2(ALARM_TICKS + 2);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_SET   = 3'd1,
        S_RUN   = 3'd2,
        S_PAUSE = 3'd3,
        S_ALARM = 3'd4
    } state_t;

    state_t             state_q, state_d;
    logic [15:0]        digits_q, digits_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d, cnt_inc;
    logic               tick_prev_q;
    logic               running_q, alarm_q;
    logic               tick_ev;
    logic               any_btn;
    logic [15:0]        dec_val;

    function automatic logic [15:0] bcd_inc(input logic [15:0] d);
        logic [3:0] s1, s10, m1, m10;
        s1  = d[3:0];
        s10 = d[7:4];
        m1  = d[11:8];
        m10 = d[15:12];
        if (s1 != 4'd9) begin
            s1 = s1 + 4'd1;
        end else begin
            s1 = 4'd0;
            if (s10 != 4'd5) begin
                s10 = s10 + 4'd1;
            end else begin
                s10 = 4'd0;
                if (m1 != 4'd9) begin
                    m1 = m1 + 4'd1;
                end else begin
                    m1  = 4'd0;
                    m10 = (m10 == 4'd5) ? 4'd0 : m10 + 4'd1;
                end
            end
        end
        return {m10, m1, s10, s1};
    endfunction

    // Caller guarantees d != 00:00, so the minute-tens borrow never underflows.
    function automatic logic [15:0] bcd_dec(input logic [15:0] d);
        logic [3:0] s1, s10, m1, m10;
        s1  = d[3:0];
        s10 = d[7:4];
        m1  = d[11:8];
        m10 = d[15:12];
        if (s1 != 4'd0) begin
            s1 = s1 - 4'd1;
        end else begin
            s1 = 4'd9;
            if (s10 != 4'd0) begin
                s10 = s10 - 4'd1;
            end else begin
                s10 = 4'd5;
                if (m1 != 4'd0) begin
                    m1 = m1 - 4'd1;
                end else begin
                    m1  = 4'd9;
                    m10 = (m10 == 4'd0) ? 4'd0 : m10 - 4'd1;
                end
            end
        end
        return {m10, m1, s10, s1};
    endfunction

    assign tick_ev = TICK_IS_LEVEL ? (tick_1hz & ~tick_prev_q) : tick_1hz;
    assign any_btn = btn_start | btn_mode | btn_inc;
    assign cnt_inc = cnt_q + CNT_W'(1);
    assign dec_val = bcd_dec(digits_q);

    always_comb begin
        state_d  = state_q;
        digits_d = digits_q;
        cnt_d    = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (btn_start) begin
                    if (digits_q != 16'h0000) state_d = S_RUN;
                end else if (btn_mode) begin
                    state_d = S_SET;
                end
            end
            S_SET: begin
                if (btn_start) begin
                    if (digits_q != 16'h0000) state_d = S_RUN;
                end else if (btn_mode) begin
                    state_d = S_IDLE;
                end else if (btn_inc) begin
                    digits_d = bcd_inc(digits_q);
                end
            end
            S_RUN: begin
                // A start pulse wins over a coincident tick: pause without decrement.
                if (btn_start) begin
                    state_d = S_PAUSE;
                end else if (tick_ev) begin
                    if (digits_q == 16'h0000 || dec_val == 16'h0000) begin
                        digits_d = 16'h0000;
                        state_d  = S_ALARM;
                        cnt_d    = '0;
                    end else begin
                        digits_d = dec_val;
                    end
                end
            end
            S_PAUSE: begin
                if (btn_start) begin
                    state_d = (digits_q != 16'h0000) ? S_RUN : S_IDLE;
                end else if (btn_mode) begin
                    state_d  = S_IDLE;
                    digits_d = 16'h0000;
                end
            end
            S_ALARM: begin
                digits_d = 16'h0000;
                if (any_btn) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end else if (tick_ev) begin
                    if (cnt_inc >= CNT_W'(ALARM_TICKS)) begin
                        state_d = S_IDLE;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_inc;
                    end
                end
            end
            default: begin
                state_d  = S_IDLE;
                digits_d = 16'h0000;
                cnt_d    = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            digits_q    <= 16'h0000;
            cnt_q       <= '0;
            tick_prev_q <= 1'b0;
            running_q   <= 1'b0;
            alarm_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            digits_q    <= digits_d;
            cnt_q       <= cnt_d;
            tick_prev_q <= tick_1hz;
            running_q   <= (state_d == S_RUN);
            alarm_q     <= (state_d == S_ALARM);
        end
    end

    assign digits  = digits_q;
    assign state   = state_q;
    assign running = running_q;
    assign alarm   = alarm_q;

endmodule

// File: doc/timer_ctrl.md
TIMER_CTRL -- requirements
Module: timer_ctrl

Interface
REQ-001 SHALL have parameter ALARM_TICKS, default 10, meaning number of tick_1hz pulses the alarm stays asserted.
REQ-002 SHALL have parameter TICK_IS_LEVEL, default 0, meaning 0 treats tick_1hz as a one-cycle pulse; 1 edge-detects tick_1hz internally.
REQ-003 SHALL have port clk  input  1  system clock; all state updates on rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset (0 = reset asserted).
REQ-005 SHALL have port tick_1hz  input  1  one-second timebase from the clock divider.
REQ-006 SHALL have port btn_start  input  1  debounced single-cycle start/pause pulse.
REQ-007 SHALL have port btn_inc  input  1  debounced single-cycle increment pulse.
REQ-008 SHALL have port btn_mode  input  1  debounced single-cycle set-mode/clear pulse.
REQ-009 SHALL have port digits  output  16  BCD MM:SS, [15:12]=min tens, [11:8]=min ones, [7:4]=sec tens, [3:0]=sec ones.
REQ-010 SHALL have port state  output  3  encoded FSM state: IDLE=0, SET=1, RUN=2, PAUSE=3, ALARM=4.
REQ-011 SHALL have port running  output  1  high only in RUN.
REQ-012 SHALL have port alarm  output  1  high only in ALARM.

Function
REQ-013 SHALL register all outputs; every change is visible one clk after the causing input is sampled.
REQ-014 SHALL keep each digit legal at all times: sec ones/min ones 0-9, sec tens/min tens 0-5.
REQ-015 SHALL resolve same-cycle buttons by priority btn_start > btn_mode > btn_inc; lower-priority pulses that cycle are discarded.
REQ-016 IDLE: btn_mode -> SET; btn_start with digits != 00:00 -> RUN; btn_start with 00:00 -> stay IDLE; btn_inc and ticks ignored.
REQ-017 SET: btn_inc adds one second with BCD carry (x9 -> next tens, 59 sec -> 00 sec and minute +1), 59:59 wraps to 00:00.
REQ-018 SET: btn_mode -> IDLE keeping digits; btn_start -> RUN if digits != 00:00, else stay SET; ticks ignored.
REQ-019 RUN: each tick subtracts one second with BCD borrow (x0 -> x-1 tens with ones 9; 00 sec -> 59 sec and minute -1).
REQ-020 RUN: tick that makes digits 00:00 SHALL enter ALARM on the same edge, alarm high the next cycle.
REQ-021 RUN: btn_start -> PAUSE; a tick in the same cycle is discarded (no decrement); btn_mode and btn_inc ignored.
REQ-022 PAUSE: digits frozen; btn_start -> RUN; btn_mode -> IDLE with digits cleared to 00:00; btn_inc and ticks ignored.
REQ-023 ALARM: digits held 00:00; internal alarm counter starts at 0 on entry and increments per tick.
REQ-024 ALARM: exit to IDLE when counter reaches ALARM_TICKS or on any button pulse, whichever first; button pulse is consumed (no further action).
REQ-025 SHALL never decrement below 00:00 nor enter RUN with 00:00.
REQ-026 Undefined state encodings (5-7) SHALL return to IDLE with digits 00:00 on the next clk.

Reset
REQ-027 reset low SHALL immediately force state=IDLE, digits=16'h0000, running=0, alarm=0, alarm counter=0, tick edge register=0.
REQ-028 reset low mid-RUN or mid-ALARM SHALL abort with the REQ-027 values; no pending tick or button is remembered after release.
REQ-029 First rising clk after reset returns high SHALL sample inputs normally.

Verification
REQ-030 Reset, mode, 75x inc, start -> digits 01:15 in SET, state=2 and running=1 one clk after start.
REQ-031 RUN from 01:00, one tick -> 00:59; further 59 ticks -> 00:00, alarm=1, state=4 on the same clk as the last tick update.
REQ-032 ALARM with ALARM_TICKS=10: 10 ticks -> state=0, alarm=0; repeat and press btn_inc after 3 ticks -> state=0 next clk, digits 00:00.
REQ-033 RUN at 00:05, btn_start and tick in same cycle -> state=3, digits 00:05; btn_mode -> state=0, digits 00:00.
REQ-034 SET at 59:59, btn_inc -> 00:00; btn_start -> remains SET; btn_start+btn_mode+btn_inc together in IDLE with 00:00 -> stays IDLE.
REQ-035 reset asserted asynchronously between clk edges during RUN at 12:34 -> outputs 00:00/IDLE before next edge; no decrement after release until a new start.
